iteration_frame_sender: RTL
===========================

Name: iteration_frame_sender

Overview:
- Downstream consumer of the octo_manager output (data_avl, sensor_iterations[271:0]).
- Captures one 272-bit iteration snapshot and serialises it as a framed UART byte stream to the host MCU.
- Issues reset_parser back to octo_manager to release the parser for the next snapshot.
- Back-pressure is implicit: the parser holds its data until reset_parser arrives.

Parameters:
CLKS_PER_BIT, 72, clock cycles per UART bit (72 MHz / 72 = 1 Mbaud); minimum 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk_72MHz  input  1  system clock
reset  input  1  asynchronous, active-high reset
data_avl  input  1  level; high while octo_manager holds a valid snapshot, stays high until reset_parser is seen
sensor_iterations  input  272  snapshot payload, stable while data_avl is high
reset_parser  output  1  one-cycle pulse acknowledging the captured snapshot
tx  output  1  UART 8N1 serial line, idle high
busy  output  1  high from capture until the last stop bit completes
frames_sent  output  16  count of completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values (asynchronous, applied immediately): tx=1, busy=0, reset_parser=0, frames_sent=0, seq=0, FSM=IDLE, shift registers cleared.
- Frame format: 37 bytes, LSB-first bits, 8N1.
  - Byte 0: SYNC_BYTE.
  - Byte 1: seq, an 8-bit frame sequence number.
  - Bytes 2..35: payload, sensor_iterations[271:264] first, down to [7:0] last.
  - Byte 36: XOR of bytes 1..35.
- FSM states: IDLE, START, DATA, STOP, NEXT.
- IDLE:
  - If data_avl=1 at edge N, latch sensor_iterations and seq into a 296-bit frame register, computing the checksum combinationally at latch time.
  - reset_parser=1 during cycle N+1 only.
  - busy=1 from N+1.
  - Go to START.
- START: tx=0 for CLKS_PER_BIT cycles (first start bit begins at N+1), then DATA.
- DATA: 8 bits, each held CLKS_PER_BIT cycles, LSB first, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then NEXT.
- NEXT (1 cycle, tx=1):
  - If byte index < 36: increment the index and go to START.
  - Otherwise: frames_sent+=1, seq+=1 (8-bit wrap), busy=0, go to IDLE.
- Frame duration: 37*10*CLKS_PER_BIT + 37 cycles from N+1 to busy falling.
- data_avl while busy is ignored; the parser keeps holding its data. If data_avl is still high when IDLE is re-entered, the next capture occurs on that very next edge (back-to-back frames, one idle cycle minimum between the stop bit and the next start bit).
- data_avl is only sampled in IDLE. A data_avl pulse that falls before IDLE is lost by design; octo_manager's contract guarantees it does not fall.
- Reset mid-frame aborts immediately: tx returns high the same cycle, no partial checksum, seq restarts at 0.
- Bit timing counter: clog2(CLKS_PER_BIT) bits, wraps per bit. Byte index: 6 bits (0..36). Bit index: 3 bits.

Decomposition:
- Shared package ivt_frame_pkg holds:
  - FRAME_BYTES=37, PAYLOAD_BYTES=34, ITER_WIDTH=17, SENSORS=8;
  - the frame byte-offset constants;
  - a checksum function (XOR reduction over bytes).
- One sub-module, uart_tx_byte, handles byte-level serialisation.
  - Inputs: start, byte[7:0]. Outputs: tx, done.
  - Owns START/DATA/STOP and the bit timer, parameterised by CLKS_PER_BIT.
- The top level owns IDLE/NEXT, the frame register, seq, frames_sent and reset_parser.

Test Plan:
- Basic frame (CLKS_PER_BIT=4): sensor_iterations = 272'h0102…22 (bytes 1..34 ascending), data_avl high at cycle 10.
  - reset_parser pulses exactly at cycle 11.
  - tx decodes A5, 00, 01..22, then checksum = 00^01^…^22.
  - busy falls at cycle 11+37*40+37; frames_sent=1.
- Back-pressure: hold data_avl high through the first frame and change sensor_iterations mid-frame.
  - The first frame carries the original data.
  - The second capture occurs on the first cycle in IDLE, with seq=01 and the new data.
  - Exactly 2 reset_parser pulses.
- All-ones payload: checksum byte = seq ^ (34 × FF) = seq (even count). Check seq=00 → checksum 00, then seq=01 → checksum 01.
- Async reset asserted during payload byte 12, mid-bit:
  - tx=1, busy=0 in the same cycle.
  - After release with data_avl high, the new frame starts with A5, 00.
- Wrap: preload 256 frames (or force the counter) → seq 0xFF→0x00, and frames_sent increments correctly. Force frames_sent=FFFF → 0000 after the next frame.
- Idle line: data_avl low for 1000 cycles → tx constantly 1, busy 0, no reset_parser pulse.

Source files
------------

// File: rtl/ivt_frame_pkg.sv
// rtl/ivt_frame_pkg.sv - frame layout constants and checksum helper for the iteration frame sender
package ivt_frame_pkg;

  localparam int ITER_WIDTH    = 17;
  localparam int SENSORS       = 8;
  localparam int PAYLOAD_WIDTH = 2 * SENSORS * ITER_WIDTH;
  localparam int PAYLOAD_BYTES = PAYLOAD_WIDTH / 8;

  localparam int OFS_SYNC    = 0;
  localparam int OFS_SEQ     = OFS_SYNC + 1;
  localparam int OFS_PAYLOAD = OFS_SEQ + 1;
  localparam int OFS_CSUM    = OFS_PAYLOAD + PAYLOAD_BYTES;
  localparam int FRAME_BYTES = OFS_CSUM + 1;
  localparam int FRAME_WIDTH = FRAME_BYTES * 8;

  // The checksum covers the sequence number and the payload, not the sync byte.
  localparam int CSUM_SPAN_BYTES = OFS_CSUM - OFS_SEQ;

  function automatic logic [7:0] xor_bytes(input logic [8*CSUM_SPAN_BYTES-1:0] data);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < CSUM_SPAN_BYTES; i++) begin
      acc = acc ^ data[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser with start/data/stop bit timing
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end = (bit_cnt == CNT_LAST);
  // Raised during the final stop-bit cycle so the caller's next step lines up with the line going idle.
  assign done = (state == ST_STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_START;
            shift   <= byte_data;
            bit_cnt <= '0;
            tx      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx      <= shift[0];
            shift   <= shift >> 1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          if (bit_end) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/iteration_frame_sender.sv
// rtl/iteration_frame_sender.sv - captures an iteration snapshot and sends it as a checksummed UART frame
module iteration_frame_sender
  import ivt_frame_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 72,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                     clk_72MHz,
  input  logic                     reset,
  input  logic                     data_avl,
  input  logic [PAYLOAD_WIDTH-1:0] sensor_iterations,
  output logic                     reset_parser,
  output logic                     tx,
  output logic                     busy,
  output logic [15:0]              frames_sent
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BYTE = 2'd1;
  localparam logic [1:0] ST_NEXT = 2'd2;

  logic [1:0]             state;
  logic [FRAME_WIDTH-1:0] frame;
  logic [FRAME_WIDTH-1:0] frame_shifted;
  logic [5:0]             byte_idx;
  logic [7:0]             seq;
  logic                   capture;
  logic                   advance;
  logic                   byte_start;
  logic                   byte_done;
  logic [7:0]             byte_data;
  logic [7:0]             csum;

  assign capture    = (state == ST_IDLE) && data_avl;
  assign advance    = (state == ST_NEXT) && (byte_idx < 6'(OFS_CSUM));
  assign byte_start = capture | advance;

  // The frame register shifts up one byte per NEXT, so the byte to send next always sits at the top.
  assign frame_shifted = frame << 8;
  assign byte_data     = capture ? SYNC_BYTE : frame_shifted[FRAME_WIDTH-1 -: 8];
  assign csum          = xor_bytes({seq, sensor_iterations});

  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      frame        <= '0;
      byte_idx     <= 6'd0;
      seq          <= 8'h00;
      frames_sent  <= 16'h0000;
      busy         <= 1'b0;
      reset_parser <= 1'b0;
    end else begin
      reset_parser <= capture;
      case (state)
        ST_IDLE: begin
          if (data_avl) begin
            frame    <= {SYNC_BYTE, seq, sensor_iterations, csum};
            byte_idx <= 6'd0;
            busy     <= 1'b1;
            state    <= ST_BYTE;
          end
        end
        ST_BYTE: begin
          if (byte_done) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (advance) begin
            frame    <= frame_shifted;
            byte_idx <= byte_idx + 6'd1;
            state    <= ST_BYTE;
          end else begin
            frames_sent <= frames_sent + 16'd1;
            seq         <= seq + 8'd1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk      (clk_72MHz),
    .rst      (reset),
    .start    (byte_start),
    .byte_data(byte_data),
    .tx       (tx),
    .done     (byte_done)
  );

endmodule
